// File: rtl/mips_cpu_hilo_muldiv_if.sv
// ---------------------------------------------------------------------------
// mips_cpu_hilo_muldiv_if
// Request/result bundle between the execute stage and the HI/LO
// multiply/divide unit.
//   start, op, a, b : request from the execute stage (master -> slave)
//   busy, done      : status back to the control FSM (slave -> master)
//   hi, lo          : architectural HI/LO registers for MFHI/MFLO
// Modports: master = execute stage / testbench, slave = mips_cpu_hilo_muldiv.
// ---------------------------------------------------------------------------
interface mips_cpu_hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_hilo_muldiv.sv
// ---------------------------------------------------------------------------
// mips_cpu_hilo_muldiv
// Iterative MIPS multiply/divide unit holding the HI/LO registers.
// Services MULT, MULTU, DIV, DIVU (32 iteration cycles, sign-magnitude
// with final correction) plus the single-cycle MTHI/MTLO moves.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous, active-high reset
//   bus   : mips_cpu_hilo_muldiv_if.slave (start/op/a/b in,
//           busy/done/hi/lo out)
// Optional build macro: MIPS_MULDIV_FAST_MULT_EN -- when defined, MULT and
// MULTU use a one-cycle combinational multiplier; divide is unchanged.
// ---------------------------------------------------------------------------
module mips_cpu_hilo_muldiv #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    mips_cpu_hilo_muldiv_if.slave   bus
);
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ITER - 2);
    localparam logic [WIDTH-1:0]   ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE2     = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   acc_hi_r, acc_lo_r;   // mul: partial product/multiplier; div: remainder/quotient
    logic [WIDTH-1:0]   oper_r;               // mul: |multiplicand|; div: |divisor|
    logic [WIDTH-1:0]   a_raw_r;              // original dividend for divide-by-zero
    logic               sign_a_r, sign_b_r, is_div_r;
    logic               busy_r, done_r;
    logic [WIDTH-1:0]   hi_r, lo_r;

    logic               accept_s, op_signed_s, sa_s, sb_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic [WIDTH:0]     mul_sum_s, rem_sh_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   step_hi_s, step_lo_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   res_hi_s, res_lo_s;

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    // Request decode and operand magnitudes (only op 0-3 start an iteration).
    always_comb begin
        accept_s    = (state_r == IDLE) && bus.start && (bus.op[2] == 1'b0);
        op_signed_s = ~bus.op[0];
        sa_s        = op_signed_s & bus.a[WIDTH-1];
        sb_s        = op_signed_s & bus.b[WIDTH-1];
        mag_a_s     = sa_s ? (~bus.a + ONE) : bus.a;
        mag_b_s     = sb_s ? (~bus.b + ONE) : bus.b;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
`ifdef MIPS_MULDIV_FAST_MULT_EN
                    if (bus.op[1]) begin
                        state_s = RUN;
                    end else begin
                        state_s = FIX;
                    end
`else
                    state_s = RUN;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = FIX;
                end else begin
                    state_s = RUN;
                end
            end
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // One iteration: shift-add multiply step or restoring divide step.
    always_comb begin
        mul_sum_s = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, oper_r} : {(WIDTH+1){1'b0}});
        rem_sh_s  = {acc_hi_r, acc_lo_r[WIDTH-1]};
        div_ge_s  = (rem_sh_s >= {1'b0, oper_r});
        if (is_div_r) begin
            if (div_ge_s) begin
                step_hi_s = WIDTH'(rem_sh_s - {1'b0, oper_r});
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = rem_sh_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end
    end

    // Final result with sign correction; divide-by-zero returns all-ones / dividend.
    always_comb begin
`ifdef MIPS_MULDIV_FAST_MULT_EN
        prod_s = {{WIDTH{1'b0}}, oper_r} * {{WIDTH{1'b0}}, acc_lo_r};
`else
        prod_s = {step_hi_s, step_lo_s};
`endif
        if (is_div_r) begin
            if (oper_r == {WIDTH{1'b0}}) begin
                res_hi_s = a_raw_r;
                res_lo_s = {WIDTH{1'b1}};
            end else begin
                res_lo_s = (sign_a_r ^ sign_b_r) ? (~step_lo_s + ONE) : step_lo_s;
                res_hi_s = sign_a_r ? (~step_hi_s + ONE) : step_hi_s;
            end
        end else begin
            if (sign_a_r ^ sign_b_r) begin
                {res_hi_s, res_lo_s} = ~prod_s + ONE2;
            end else begin
                {res_hi_s, res_lo_s} = prod_s;
            end
        end
    end

    // Datapath, HI/LO and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r    <= {CNT_W{1'b0}};
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
            oper_r   <= {WIDTH{1'b0}};
            a_raw_r  <= {WIDTH{1'b0}};
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            is_div_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cnt_r    <= {CNT_W{1'b0}};
                        acc_hi_r <= {WIDTH{1'b0}};
                        acc_lo_r <= bus.op[1] ? mag_a_s : mag_b_s;
                        oper_r   <= bus.op[1] ? mag_b_s : mag_a_s;
                        a_raw_r  <= bus.a;
                        sign_a_r <= sa_s;
                        sign_b_r <= sb_s;
                        is_div_r <= bus.op[1];
                        busy_r   <= 1'b1;
                    end else if (bus.start && (bus.op == 3'd4)) begin
                        hi_r <= bus.a;
                    end else if (bus.start && (bus.op == 3'd5)) begin
                        lo_r <= bus.a;
                    end
                end
                RUN: begin
                    acc_hi_r <= step_hi_s;
                    acc_lo_r <= step_lo_s;
                    cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                FIX: begin
                    hi_r   <= res_hi_s;
                    lo_r   <= res_lo_s;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
